// File: rtl/barcode_rx.sv
// Barcode receiver: calibrates a bit period from a leading low pulse, then samples ID_W bits MSB-first.
// Optional BARCODE_RX_TIMEOUT_EN adds a 4*L no-edge timeout in WAIT_FALL/SAMPLE.
module barcode_rx #(
    parameter int ID_W  = 8,
    parameter int HDR_W = 2,
    parameter int CNT_W = 22
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            BC_async,
    input  logic            clr_ID_vld,
    output logic            ID_vld,
    output logic [ID_W-1:0] ID,
    output logic            ID_err,
    output logic            busy
);

    localparam int IDX_W = $clog2(ID_W + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CAL       = 2'd1,
        WAIT_FALL = 2'd2,
        SAMPLE    = 2'd3
    } state_t;

    state_t            state_q;
    logic              bc_meta_q, bc_s_q, bc_prev_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cal_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [ID_W-1:0]   shift_q;
    logic [ID_W-1:0]   id_q;
    logic              id_vld_q, id_err_q, busy_q;

    logic              fall_edge;
    logic              cnt_max;
    logic [CNT_W-1:0]  cnt_d;
    logic [ID_W-1:0]   shift_d;
    logic              hdr_ok;
    logic              frame_done;

    assign fall_edge  = bc_prev_q & ~bc_s_q;
    assign cnt_max    = &cnt_q;
    assign cnt_d      = cnt_max ? cnt_q : cnt_q + CNT_W'(1);
    assign shift_d    = {shift_q[ID_W-2:0], bc_s_q};
    assign frame_done = (bit_idx_q == IDX_W'(ID_W));

    generate
        if (HDR_W == 0) begin : g_no_hdr
            assign hdr_ok = 1'b1;
        end else begin : g_hdr
            assign hdr_ok = ~|shift_q[ID_W-1 -: HDR_W];
        end
    endgenerate

`ifdef BARCODE_RX_TIMEOUT_EN
    logic [CNT_W+1:0] limit;
    logic             timeout;
    assign limit   = {cal_q, 2'b00};
    assign timeout = ({2'b00, cnt_q} > limit);
`endif

    // NOTE: every register here, including the frame shift register, is reset;
    // the synchroniser resets to the idle-high level so release cannot fake an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bc_meta_q <= 1'b1;
            bc_s_q    <= 1'b1;
            bc_prev_q <= 1'b1;
            cnt_q     <= '0;
            cal_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            id_q      <= '0;
            id_vld_q  <= 1'b0;
            id_err_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so later assignments below override earlier ones.
            bc_meta_q <= BC_async;
            bc_s_q    <= bc_meta_q;
            bc_prev_q <= bc_s_q;
            id_err_q  <= 1'b0;
            if (clr_ID_vld) id_vld_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (fall_edge) begin
                        cnt_q   <= '0;
                        state_q <= CAL;
                        busy_q  <= 1'b1;
                    end
                end
                CAL: begin
                    if (!bc_s_q) begin
                        if (cnt_max) begin
                            id_err_q <= 1'b1;
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else if (cnt_q < CNT_W'(2)) begin
                        id_err_q <= 1'b1;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end else begin
                        cal_q     <= cnt_q;
                        bit_idx_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= WAIT_FALL;
                    end
                end
                WAIT_FALL: begin
                    if (frame_done) begin
                        // Valid-frame set is written after the clear, so it wins a tie.
                        if (hdr_ok) begin
                            id_q     <= shift_q;
                            id_vld_q <= 1'b1;
                        end else begin
                            id_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (fall_edge) begin
                        cnt_q   <= '0;
                        state_q <= SAMPLE;
`ifdef BARCODE_RX_TIMEOUT_EN
                    end else if (timeout) begin
                        id_err_q <= 1'b1;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
`endif
                    end
                end
                SAMPLE: begin
                    if (cnt_q == cal_q) begin
                        shift_q   <= shift_d;
                        bit_idx_q <= bit_idx_q + IDX_W'(1);
                        cnt_q     <= '0;
                        state_q   <= WAIT_FALL;
`ifdef BARCODE_RX_TIMEOUT_EN
                    end else if (timeout) begin
                        id_err_q <= 1'b1;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ID_vld = id_vld_q;
    assign ID     = id_q;
    assign ID_err = id_err_q;
    assign busy   = busy_q;

endmodule
